// File: rtl/hamming_encoder.sv
// hamming_encoder: registered Hamming SEC parity generator, 1-cycle latency by default.
// Define HAMMING_ENC_IN_REG_EN to add an asynchronously reset input register stage (2-cycle latency).
module hamming_encoder #(
    parameter  int unsigned DATA_WIDTH = 8,
    // Smallest r with 2^r >= DATA_WIDTH + r + 1, valid for DATA_WIDTH 4..64.
    localparam int unsigned CODE_BITS  = (DATA_WIDTH <= 4)  ? 3 :
                                         (DATA_WIDTH <= 11) ? 4 :
                                         (DATA_WIDTH <= 26) ? 5 :
                                         (DATA_WIDTH <= 57) ? 6 : 7
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  valid_in_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic [CODE_BITS-1:0]  parity_bits_o,
    output logic                  valid_out_o
);

    // Codeword position of data bit idx: the idx-th position that is not a power of two.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [DATA_WIDTH-1:0] enc_data;
    logic                  enc_valid;
    logic [CODE_BITS-1:0]  parity;

`ifdef HAMMING_ENC_IN_REG_EN
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in_i;
            if (valid_in_i) data_q <= data_in_i;
        end
    end

    assign enc_data  = data_q;
    assign enc_valid = valid_q;
`else
    assign enc_data  = data_in_i;
    assign enc_valid = valid_in_i;
`endif

    for (genvar i = 0; i < CODE_BITS; i++) begin : g_parity
        logic [DATA_WIDTH-1:0] mask;
        for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_mask
            localparam int unsigned POS = data_pos(d);
            assign mask[d] = POS[i];
        end
        assign parity[i] = ^(enc_data & mask);
    end

    // Outputs only load on valid, so X on idle inputs never reaches them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out_o    <= '0;
            parity_bits_o <= '0;
            valid_out_o   <= 1'b0;
        end else begin
            valid_out_o <= enc_valid;
            if (enc_valid) begin
                data_out_o    <= enc_data;
                parity_bits_o <= parity;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder.sv
// tb_hamming_encoder: scoreboard bench for hamming_encoder at DATA_WIDTH 8, 16 and 32.
// Honours HAMMING_ENC_IN_REG_EN for the expected latency.
module tb_hamming_encoder;

`ifdef HAMMING_ENC_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [7:0]  din8;
    logic [15:0] din16;
    logic [31:0] din32;
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic [31:0] dout32;
    logic [3:0]  par8;
    logic [4:0]  par16;
    logic [5:0]  par32;
    logic        vld8, vld16, vld32;

    always #5 clk = ~clk;

    hamming_encoder #(.DATA_WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in_i(din8), .valid_in_i(valid_in),
        .data_out_o(dout8), .parity_bits_o(par8), .valid_out_o(vld8)
    );
    hamming_encoder #(.DATA_WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in_i(din16), .valid_in_i(valid_in),
        .data_out_o(dout16), .parity_bits_o(par16), .valid_out_o(vld16)
    );
    hamming_encoder #(.DATA_WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in_i(din32), .valid_in_i(valid_in),
        .data_out_o(dout32), .parity_bits_o(par32), .valid_out_o(vld32)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  p8;
        logic [4:0]  p16;
        logic [5:0]  p32;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [1:0]  vpipe;
    logic        exp_v;
    bit          syn_en = 1'b0;
    int          syn_words = 0;
    int          n_asserts = 0;
    int          n_fail = 0;

    // Reference: scatter data into non-power-of-two positions, then even parity per bit plane.
    function automatic logic [127:0] assemble(input logic [63:0] d, input logic [7:0] p,
                                              input int w, input int cb);
        logic [127:0] cw;
        int di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= w + cb; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                for (int i = 0; i < cb; i++) if (pos == (1 << i)) cw[pos] = p[i];
            end else begin
                cw[pos] = d[di];
                di++;
            end
        end
        return cw;
    endfunction

    function automatic logic [7:0] ref_par(input logic [63:0] d, input int w, input int cb);
        logic [127:0] cw;
        logic [7:0]   p;
        cw = assemble(d, 8'h00, w, cb);
        p = '0;
        for (int i = 0; i < cb; i++)
            for (int pos = 1; pos <= w + cb; pos++)
                if (((pos >> i) & 1) == 1) p[i] = p[i] ^ cw[pos];
        return p;
    endfunction

    function automatic int syndrome(input logic [127:0] cw, input int n);
        int s;
        s = 0;
        for (int pos = 1; pos <= n; pos++) if (cw[pos]) s = s ^ pos;
        return s;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] d);
        exp_t e;
        logic [7:0] p;
        e.d = d;
        p = ref_par({56'h0, d[7:0]}, 8, 4);
        e.p8 = p[3:0];
        p = ref_par({48'h0, d[15:0]}, 16, 5);
        e.p16 = p[4:0];
        p = ref_par({32'h0, d}, 32, 6);
        e.p32 = p[5:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic syn_check(input string tag, input logic [63:0] d, input logic [7:0] p,
                             input int w, input int cb);
        logic [127:0] cw;
        logic [127:0] flipped;
        cw = assemble(d, p, w, cb);
        chk({tag, ".clean"}, 64'(syndrome(cw, w + cb)), 64'd0);
        for (int pos = 1; pos <= w + cb; pos++) begin
            flipped = cw;
            flipped[pos] = ~flipped[pos];
            chk({tag, ".flip"}, 64'(syndrome(flipped, w + cb)), 64'(pos));
        end
    endtask

    task automatic check_outputs();
        chk("vld8", {63'h0, vld8}, {63'h0, exp_v});
        chk("vld16", {63'h0, vld16}, {63'h0, exp_v});
        chk("vld32", {63'h0, vld32}, {63'h0, exp_v});
        chk("dout8", {56'h0, dout8}, {56'h0, cur.d[7:0]});
        chk("dout16", {48'h0, dout16}, {48'h0, cur.d[15:0]});
        chk("dout32", {32'h0, dout32}, {32'h0, cur.d});
        chk("par8", {60'h0, par8}, {60'h0, cur.p8});
        chk("par16", {59'h0, par16}, {59'h0, cur.p16});
        chk("par32", {58'h0, par32}, {58'h0, cur.p32});
        if (syn_en && exp_v && syn_words < 10) begin
            syn_check("syn8", {56'h0, dout8}, {4'h0, par8}, 8, 4);
            syn_check("syn16", {48'h0, dout16}, {3'h0, par16}, 16, 5);
            syn_check("syn32", {32'h0, dout32}, {2'h0, par32}, 32, 6);
            syn_words++;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d);
        valid_in = v;
        if (v) begin
            din8 = d[7:0];
            din16 = d[15:0];
            din32 = d;
            exp_q.push_back(make_exp(d));
        end else begin
            din8 = 'x;
            din16 = 'x;
            din32 = 'x;
        end
        @(posedge clk);
        #1;
        vpipe = {vpipe[0], v};
        exp_v = vpipe[LAT-1];
        if (exp_v && exp_q.size() > 0) cur = exp_q.pop_front();
        check_outputs();
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        vpipe = '0;
        exp_v = 1'b0;
        cur = '{d: '0, p8: '0, p16: '0, p32: '0};
        check_outputs();
    endtask

    task automatic single(input logic [7:0] word, input logic [3:0] p_req);
        cycle(1'b1, {24'h0, word});
        repeat (LAT - 1) cycle(1'b0, 'x);
        chk("tp.par8", {60'h0, par8}, {60'h0, p_req});
        chk("tp.dout8", {56'h0, dout8}, {56'h0, word});
        chk("tp.vld8", {63'h0, vld8}, 64'd1);
        cycle(1'b0, 'x);
        chk("tp.vld8_off", {63'h0, vld8}, 64'd0);
        chk("tp.hold8", {56'h0, dout8}, {56'h0, word});
    endtask

    initial begin
        rst_n = 1'b1;
        valid_in = 1'b0;
        din8 = 'x;
        din16 = 'x;
        din32 = 'x;
        vpipe = '0;
        #1;
        reset_now();
        repeat (2) cycle(1'b0, 'x);
        rst_n = 1'b1;
        repeat (5) cycle(1'b0, 'x);

        single(8'h01, 4'b0011);
        single(8'h80, 4'b1100);
        single(8'hFF, 4'b0011);
        single(8'hA5, 4'b0011);
        single(8'h00, 4'b0000);

        cycle(1'b1, 32'h0000_0001);
        cycle(1'b1, 32'h0000_0080);
        cycle(1'b1, 32'h0000_00FF);
        repeat (LAT + 1) cycle(1'b0, 'x);

        // Reset one cycle after a valid word: nothing may emerge afterwards.
        cycle(1'b1, 32'h0000_0080);
        reset_now();
        cycle(1'b0, 'x);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 'x);

        syn_en = 1'b1;
        repeat (1300) cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, $urandom);
        repeat (LAT + 1) cycle(1'b0, 'x);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_encoder.md
Name: hamming_encoder

Overview:
- Registered Hamming single-error-correcting (SEC) parity generator.
- Takes one DATA_WIDTH data word per valid cycle. One cycle later it presents the same data word, its CODE_BITS Hamming parity bits and a valid strobe.
- Sits beside the serializer when ECC is enabled. The serializer shifts the parity bits out after the data bits.

Parameters:
- DATA_WIDTH, default 8, width of the data word; legal range 4..64.
- CODE_BITS, derived localparam (not overridable): smallest r with 2^r >= DATA_WIDTH + r + 1.
  - DATA_WIDTH 8 gives 4; 16 gives 5; 32 gives 6.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- data_in_i  input  DATA_WIDTH  data word to encode.
- valid_in_i  input  1  data_in_i is valid this cycle.
- data_out_o  output  DATA_WIDTH  registered copy of the encoded data word.
- parity_bits_o  output  CODE_BITS  registered Hamming parity bits.
- valid_out_o  output  1  data_out_o and parity_bits_o are valid this cycle (single-cycle pulse per input word).

Behaviour:
- Interface:
  - One clock (clk_i); reset is asynchronous and active-low (rst_n_i).
  - No ready/backpressure; a word is accepted on every cycle valid_in_i=1.
- Reset: while rst_n_i=0, data_out_o=0, parity_bits_o=0, valid_out_o=0, regardless of clock.
  - Reset asserted mid-operation discards the in-flight word.
  - First valid output after release comes one cycle after the first sampled valid_in_i=1.
- Codeword layout:
  - Positions numbered 1..N, with N = DATA_WIDTH + CODE_BITS.
  - Positions 2^i (i = 0..CODE_BITS-1) hold parity bit i.
  - Remaining positions, in ascending order, hold data_in_i[0], data_in_i[1], ... up to data_in_i[DATA_WIDTH-1].
  - For DATA_WIDTH=8: data bits 0..7 sit at positions 3,5,6,7,9,10,11,12.
- Parity (even): parity_bits_o[i] = XOR of every data bit whose position has bit i set.
  - Purely combinational from data_in_i, then registered.
- Latency: exactly 1 cycle.
  - On a rising edge with valid_in_i=1: data_out_o<=data_in_i, parity_bits_o<=parity(data_in_i), valid_out_o<=1.
  - On an edge with valid_in_i=0: valid_out_o<=0; data_out_o and parity_bits_o hold their previous values.
- Throughput: back-to-back valid words each cycle give back-to-back outputs, one per cycle, in order. There is no internal state beyond the output registers.
- The parity computation must be generated by loops over DATA_WIDTH/CODE_BITS, with no tables hard-coded per width.
- X on data_in_i while valid_in_i=0 must not propagate to the outputs.

Optional Feature:
- Macro: HAMMING_ENC_IN_REG_EN.
- Defined:
  - data_in_i and valid_in_i are first captured in an input register stage, which is also asynchronously reset to 0.
  - Parity is computed from the registered word, so total latency is 2 cycles.
  - Throughput and hold behaviour are otherwise identical.
- Undefined: no input stage; latency is 1 cycle as above.

Test Plan:
- DATA_WIDTH=8, reset asserted asynchronously with no clock edge -> all outputs 0 immediately. After release with valid_in_i=0 for 5 cycles -> valid_out_o stays 0.
- data_in_i=8'h01 with one-cycle valid -> next cycle data_out_o=8'h01, parity_bits_o=4'b0011, valid_out_o=1; following cycle valid_out_o=0 and outputs held.
- Single-word checks, one valid cycle each:
  - 8'h80 -> parity_bits_o=4'b1100.
  - 8'hFF -> parity_bits_o=4'b0011.
  - 8'hA5 -> parity_bits_o=4'b0011.
  - 8'h00 -> parity_bits_o=4'b0000.
- Back-to-back words 8'h01, 8'h80, 8'hFF on consecutive cycles -> valid_out_o high for 3 consecutive cycles with parity 4'b0011, 4'b1100, 4'b0011 in order.
- Reset pulsed low one cycle after valid 8'h80 -> outputs forced to 0 and valid_out_o=0, with no stale pulse after release.
- Random 1000 words at DATA_WIDTH=8, 16 and 32 -> parity_bits_o matches a reference Hamming model. Flipping any single bit of the assembled codeword yields a syndrome equal to the flipped position.
